fwd_hazard_unit: RTL and testbench

Parametrised successor to the pipeline's ALU forwarding logic. It adds per-operand independent forwarding priority, configurable register-address width, load-use hazard detection with a multi-cycle stall sequencer sized for the memory latency, and saturating performance counters. It sits beside the ID/EX stage and drives the EX operand muxes, PC/IF-ID write enables and the ID/EX bubble insertion.

---
 rtl/fwd_hazard_unit.sv | 185 ++++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Purpose:
//   This block sits beside the ID/EX stage of the pipeline. It does three jobs:
//   - It selects the EX operand forwarding source for each ALU operand on its
//     own. EX/MEM wins over MEM/WB, and register 0 is never forwarded.
//   - It detects load-use hazards. It then holds PC and IF/ID, and inserts
//     ID/EX bubbles, for exactly MEM_LAT consecutive cycles.
//   - It keeps saturating counters of stall cycles and forwarding cycles.
//
// Handshake / timing:
//   There is no valid/ready handshake on this block. The forwarding selects
//   and stall/bubble are purely combinational functions of the pipeline
//   register fields and the stall sequencer state. The sequencer state and
//   both counters advance on the rising edge of clk.
//
// Ports:
//   clk, reset           rising-edge clock; synchronous active-high reset
//   ifid_rs/rt           source registers of the IF/ID instruction
//   ifid_use_rs/rt       IF/ID instruction actually reads rs / rt
//   idex_rs/rt/rd        register fields of the ID/EX instruction
//   idex_memread         ID/EX instruction is a load
//   exmem_regwrite/rd    EX/MEM write-back enable and destination
//   memwb_regwrite/rd    MEM/WB write-back enable and destination
//   forward_a/b          operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall                hold PC and IF/ID
//   bubble               zero ID/EX control (always equal to stall)
//   stall_count          saturating count of stall cycles
//   fwd_count            saturating count of cycles with any forwarding
//   dbg_state            sequencer state (0 = IDLE, 1 = HOLD), for checkers
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_use_rs,
    input  logic              ifid_use_rt,
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_memread,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  fwd_count,
    output logic [0:0]        dbg_state
);

    localparam logic [0:0]       IDLE    = 1'b0;
    localparam logic [0:0]       HOLD    = 1'b1;
    localparam logic [3:0]       LAT_M1  = 4'(MEM_LAT - 1);
    localparam logic             MULTI   = (MEM_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Forwarding: each operand is resolved on its own.
    // ------------------------------------------------------------------
    logic exmem_ok;
    logic memwb_ok;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign exmem_ok = exmem_regwrite && (exmem_rd != '0);
    assign memwb_ok = memwb_regwrite && (memwb_rd != '0);

    always_comb begin
        fwd_a_raw = 2'b00;
        if (exmem_ok && (exmem_rd == idex_rs)) begin
            fwd_a_raw = 2'b10;
        end else if (memwb_ok && (memwb_rd == idex_rs)) begin
            fwd_a_raw = 2'b01;
        end
    end

    always_comb begin
        fwd_b_raw = 2'b00;
        if (exmem_ok && (exmem_rd == idex_rt)) begin
            fwd_b_raw = 2'b10;
        end else if (memwb_ok && (memwb_rd == idex_rt)) begin
            fwd_b_raw = 2'b01;
        end
    end

    // While reset is high, the outputs are forced to their quiet values.
    assign forward_a = reset ? 2'b00 : fwd_a_raw;
    assign forward_b = reset ? 2'b00 : fwd_b_raw;

    // ------------------------------------------------------------------
    // Load-use hazard detection and stall sequencer.
    // The IDLE cycle that sees the hazard is the first stall cycle. HOLD
    // covers the remaining MEM_LAT-1 cycles, so cnt counts down from
    // MEM_LAT-1 and the sequencer leaves HOLD when cnt reaches 1.
    // ------------------------------------------------------------------
    logic       hz;
    logic [0:0] state_q;
    logic [0:0] state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       stall_raw;

    assign hz = idex_memread && (idex_rd != '0) &&
                ((ifid_use_rs && (idex_rd == ifid_rs)) ||
                 (ifid_use_rt && (idex_rd == ifid_rt)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                stall_raw = hz;
                if (hz && MULTI) begin
                    state_d = HOLD;
                    cnt_d   = LAT_M1;
                end
            end
            HOLD: begin
                // A hazard seen here is ignored; it is covered by this stall.
                stall_raw = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall     = reset ? 1'b0 : stall_raw;
    assign bubble    = stall;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Saturating performance counters.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] fwd_count_q;
    logic             fwd_any;

    assign fwd_any = (forward_a != 2'b00) || (forward_b != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            if (stall && (stall_count_q != CNT_MAX)) begin
                stall_count_q <= stall_count_q + CNT_ONE;
            end
            if (fwd_any && (fwd_count_q != CNT_MAX)) begin
                fwd_count_q <= fwd_count_q + CNT_ONE;
            end
        end
    end

    assign stall_count = stall_count_q;
    assign fwd_count   = fwd_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit. It builds three instances that share all inputs:
//   inst 0: MEM_LAT=1, CNT_W=16
//   inst 1: MEM_LAT=3, CNT_W=3
//   inst 2: MEM_LAT=4, CNT_W=16
// The reference model tracks only the "remaining forced stall cycles" and
// the integer counter values for each instance.
module tb_fwd_hazard_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic       ifid_use_rs, ifid_use_rt, idex_memread, exmem_regwrite, memwb_regwrite;

  logic [1:0]  fa_a [3];
  logic [1:0]  fb_a [3];
  logic        st_a [3];
  logic        bb_a [3];
  logic [15:0] sc_a [3];
  logic [15:0] fc_a [3];
  logic [0:0]  dbg_a [3];
  logic [15:0] sc0, fc0, sc2, fc2;
  logic [2:0]  sc1, fc1;

  int checks = 0;
  int errors = 0;
  int rem  [3];
  int scnt [3];
  int fcnt [3];
  int lat  [3] = '{1, 3, 4};
  int cmax [3] = '{65535, 7, 65535};

  always #5 clk = ~clk;

  assign sc_a[0] = sc0;
  assign fc_a[0] = fc0;
  assign sc_a[1] = {13'd0, sc1};
  assign fc_a[1] = {13'd0, fc1};
  assign sc_a[2] = sc2;
  assign fc_a[2] = fc2;

  fwd_hazard_unit #(.REG_AW(5), .MEM_LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt), .idex_rs(idex_rs),
    .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .forward_a(fa_a[0]), .forward_b(fb_a[0]), .stall(st_a[0]), .bubble(bb_a[0]),
    .stall_count(sc0), .fwd_count(fc0), .dbg_state(dbg_a[0]));

  fwd_hazard_unit #(.REG_AW(5), .MEM_LAT(3), .CNT_W(3)) u_l3 (
    .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt), .idex_rs(idex_rs),
    .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .forward_a(fa_a[1]), .forward_b(fb_a[1]), .stall(st_a[1]), .bubble(bb_a[1]),
    .stall_count(sc1), .fwd_count(fc1), .dbg_state(dbg_a[1]));

  fwd_hazard_unit #(.REG_AW(5), .MEM_LAT(4), .CNT_W(16)) u_l4 (
    .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt), .idex_rs(idex_rs),
    .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .forward_a(fa_a[2]), .forward_b(fb_a[2]), .stall(st_a[2]), .bubble(bb_a[2]),
    .stall_count(sc2), .fwd_count(fc2), .dbg_state(dbg_a[2]));

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (reset) return 2'b00;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == src) return 2'b10;
    if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_hz();
    return idex_memread && idex_rd != 5'd0 &&
           ((ifid_use_rs && idex_rd == ifid_rs) || (ifid_use_rt && idex_rd == ifid_rt));
  endfunction

  function automatic logic exp_st(input int i);
    if (reset) return 1'b0;
    return (rem[i] > 0) || ref_hz();
  endfunction

  // Advance one clock and update the model with the values of the cycle
  // that just ended.
  task automatic tick();
    logic s [3];
    logic f;
    logic h;
    h = ref_hz();
    f = (ref_fwd(idex_rs) != 2'b00) || (ref_fwd(idex_rt) != 2'b00);
    for (int i = 0; i < 3; i++) s[i] = exp_st(i);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
      end else begin
        if (s[i] && scnt[i] < cmax[i]) scnt[i]++;
        if (f && fcnt[i] < cmax[i]) fcnt[i]++;
        if (rem[i] > 0) rem[i]--;
        else if (h) rem[i] = lat[i] - 1;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    ifid_rs = 0; ifid_rt = 0; ifid_use_rs = 0; ifid_use_rt = 0;
    idex_rs = 0; idex_rt = 0; idex_rd = 0; idex_memread = 0;
    exmem_regwrite = 0; exmem_rd = 0; memwb_regwrite = 0; memwb_rd = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    exmem_regwrite = 1; exmem_rd = 3; idex_rs = 3;
    idex_memread = 1; idex_rd = 7; ifid_rs = 7; ifid_use_rs = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st_a[i] !== 1'b0 || bb_a[i] !== 1'b0 || fa_a[i] !== 2'b00 || fb_a[i] !== 2'b00) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got st=%0b bb=%0b fa=%b fb=%b exp all 0",
                 i, st_a[i], bb_a[i], fa_a[i], fb_a[i]);
      end
    end
    tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sc_a[i] !== 16'd0 || fc_a[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_counters inst%0d got sc=%0d fc=%0d exp 0 0", i, sc_a[i], fc_a[i]);
      end
    end
    reset = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_independent_fwd();
    do_reset();
    exmem_regwrite = 1; exmem_rd = 3; memwb_regwrite = 1; memwb_rd = 4;
    idex_rs = 3; idex_rt = 4;
    @(negedge clk);
    checks++;
    if (fa_a[0] !== 2'b10 || fb_a[0] !== 2'b01) begin
      errors++;
      $display("FAIL indep_fwd got fa=%b fb=%b exp fa=10 fb=01", fa_a[0], fb_a[0]);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (fc_a[0] !== 16'd1) begin
      errors++;
      $display("FAIL indep_fwd_count got %0d exp 1", fc_a[0]);
    end
    tick();
  endtask

  task automatic test_priority();
    logic [1:0] exp_sel [3] = '{2'b10, 2'b00, 2'b01};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exmem_regwrite = (k == 2) ? 1'b0 : 1'b1;
      memwb_regwrite = 1;
      exmem_rd = (k == 1) ? 5'd0 : 5'd5;
      memwb_rd = (k == 1) ? 5'd0 : 5'd5;
      idex_rs  = (k == 1) ? 5'd0 : 5'd5;
      idex_rt  = (k == 1) ? 5'd0 : 5'd5;
      @(negedge clk);
      checks++;
      if (fa_a[0] !== exp_sel[k] || fb_a[0] !== exp_sel[k]) begin
        errors++;
        $display("FAIL priority case%0d got fa=%b fb=%b exp %b", k, fa_a[0], fb_a[0], exp_sel[k]);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    // The no-use variant comes first, so it cannot start a hold.
    do_reset();
    idex_memread = 1; idex_rd = 7; ifid_rt = 7; ifid_use_rt = 0; ifid_rs = 2;
    @(negedge clk);
    checks++;
    if (st_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL load_use_nouse got stall=%0b exp 0", st_a[0]);
    end
    tick();
    ifid_use_rt = 1;
    @(negedge clk);
    checks++;
    if (st_a[0] !== 1'b1 || bb_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL load_use_hit got st=%0b bb=%0b exp 1 1", st_a[0], bb_a[0]);
    end
    tick();
    idex_memread = 0;
    @(negedge clk);
    checks++;
    if (st_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL load_use_len got stall=%0b exp 0", st_a[0]);
    end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_multi_stall();
    logic exp_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    idex_memread = 1; idex_rd = 9; ifid_rs = 9; ifid_use_rs = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (st_a[1] !== exp_seq[c] || bb_a[1] !== exp_seq[c]) begin
        errors++;
        $display("FAIL multi_stall cyc%0d got st=%0b bb=%0b exp %0b", c, st_a[1], bb_a[1], exp_seq[c]);
      end
      tick();
      idex_memread = 0;
    end
    @(negedge clk);
    checks++;
    if (sc_a[1] !== 16'd3) begin
      errors++;
      $display("FAIL multi_stall_count got %0d exp 3", sc_a[1]);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    idex_memread = 1; idex_rd = 6; ifid_rt = 6; ifid_use_rt = 1;
    @(negedge clk);
    checks++;
    if (st_a[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_hold_first got stall=%0b exp 1", st_a[2]);
    end
    tick();
    idex_memread = 0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (st_a[2] !== 1'b0 || bb_a[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold_reset got st=%0b bb=%0b exp 0 0", st_a[2], bb_a[2]);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (st_a[2] !== 1'b0 || sc_a[2] !== 16'd0 || fc_a[2] !== 16'd0) begin
      errors++;
      $display("FAIL mid_hold_after got st=%0b sc=%0d fc=%0d exp 0 0 0", st_a[2], sc_a[2], fc_a[2]);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    exmem_regwrite = 1; exmem_rd = 12; idex_rs = 12;
    for (int k = 1; k <= 10; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (fc_a[1] !== 16'((k > 7) ? 7 : k) || fc_a[0] !== 16'(k)) begin
        errors++;
        $display("FAIL saturation cyc%0d got fc3=%0d fc16=%0d exp %0d %0d",
                 k, fc_a[1], fc_a[0], (k > 7) ? 7 : k, k);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 39) == 0);
      ifid_rs        = 5'($urandom_range(0, 3));
      ifid_rt        = 5'($urandom_range(0, 3));
      ifid_use_rs    = 1'($urandom_range(0, 1));
      ifid_use_rt    = 1'($urandom_range(0, 1));
      idex_rs        = 5'($urandom_range(0, 3));
      idex_rt        = 5'($urandom_range(0, 3));
      idex_rd        = 5'($urandom_range(0, 3));
      idex_memread   = ($urandom_range(0, 3) == 0);
      exmem_regwrite = 1'($urandom_range(0, 1));
      exmem_rd       = 5'($urandom_range(0, 3));
      memwb_regwrite = 1'($urandom_range(0, 1));
      memwb_rd       = 5'($urandom_range(0, 3));
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (fa_a[i] !== ref_fwd(idex_rs) || fb_a[i] !== ref_fwd(idex_rt) ||
            st_a[i] !== exp_st(i) || bb_a[i] !== exp_st(i) ||
            sc_a[i] !== 16'(scnt[i]) || fc_a[i] !== 16'(fcnt[i])) begin
          errors++;
          $display("FAIL random n%0d inst%0d got fa=%b fb=%b st=%0b bb=%0b sc=%0d fc=%0d exp fa=%b fb=%b st=%0b sc=%0d fc=%0d",
                   n, i, fa_a[i], fb_a[i], st_a[i], bb_a[i], sc_a[i], fc_a[i],
                   ref_fwd(idex_rs), ref_fwd(idex_rt), exp_st(i), scnt[i], fcnt[i]);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
    end
    clear_inputs();
    reset = 1'b1;
    #1;
    tick();
    test_reset();
    test_independent_fwd();
    test_priority();
    test_load_use();
    test_multi_stall();
    test_reset_mid_hold();
    test_saturation();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
